multdiv_unit: RTL and testbench

- Iterative signed multiply/divide unit that executes the mult and div operations the decode stage flags on ALU opcodes 00110/00111.
- Execute stage pulses ctrl_MULT or ctrl_DIV with operands, then stalls until data_resultRDY.
- One operation in flight at a time.
- Fixed-latency multi-cycle datapath. No pipelining across operations.

---
 rtl/multdiv_unit_pkg.sv | 18 +
 rtl/multdiv_unit_div_step.sv | 29 ++
 rtl/multdiv_unit.sv | 148 ++++++++++++++
 tb/tb_multdiv_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the decode logic.
package multdiv_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam int               MD_WIDTH = 32;
  localparam logic [MD_WIDTH-1:0] INT_MIN = 32'h8000_0000;

  // ALU opcodes that decode flags as multi-cycle mult/div
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The next dividend bit comes from the MSB of quo_i; the quotient bit enters at the LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // shift in one dividend bit, keep the difference when it does not go negative
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Fixed latency: RDY pulses ITER+1 cycles after the start cycle, regardless of data.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int              CW    = $clog2(ITER + 1);
  localparam logic [CW-1:0]   LAST  = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  // shared datapath: hi = Booth accumulator / partial remainder, lo = multiplier / dividend-quotient
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q;
  logic             neg_q, dz_q, ovf_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q, rdy_q, busy_q;

  logic [WIDTH:0]   m_ext, booth_sum, hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   prod_top;
  logic             mul_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] div_rem, div_quo, quo_fix;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (hi_q[WIDTH-1:0]),
    .quo_i (lo_q),
    .dvs_i (m_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Booth step, overflow detect on the final product, operand magnitudes and quotient sign fix
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + m_ext;
      2'b10:   booth_sum = hi_q - m_ext;
      default: booth_sum = hi_q;
    endcase
    hi_d     = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    lo_d     = {booth_sum[0], lo_q[WIDTH-1:1]};
    // product bits [2W-1:W-1] must all match for the low half to be exact
    prod_top = {hi_d[WIDTH-1:0], lo_d[WIDTH-1]};
    mul_ovf  = ~((&prod_top) | ~(|prod_top));
    a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    quo_fix  = neg_q ? -div_quo : div_quo;
  end

  // control FSM and datapath registers; outputs are registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // both starts together is illegal and ignored
          if (ctrl_MULT ^ ctrl_DIV) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            hi_q   <= '0;
            qm1_q  <= 1'b0;
            if (ctrl_MULT) begin
              state_q <= MULT;
              m_q     <= data_operandA;
              lo_q    <= data_operandB;
            end else begin
              state_q <= DIV;
              m_q     <= b_mag;
              lo_q    <= a_mag;
              neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              dz_q    <= (data_operandB == '0);
              ovf_q   <= (data_operandA == MIN_V) && (&data_operandB);
            end
          end
        end
        MULT: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          qm1_q <= lo_q[0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            rdy_q    <= 1'b1;
            result_q <= lo_d;
            exc_q    <= mul_ovf;
          end
        end
        DIV: begin
          hi_q  <= {1'b0, div_rem};
          lo_q  <= div_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            rdy_q    <= 1'b1;
            // INT_MIN/-1 wraps to INT_MIN through the sign fix
            result_q <= dz_q ? '0 : quo_fix;
            exc_q    <= dz_q | ovf_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, mult/div results, exceptions, protocol, reset abort.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Called at a negedge in an IDLE cycle; returns at the negedge of the RDY cycle.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc);
    data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    lat = 0; res = 'x; exc = 1'bx;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = n; res = data_result; exc = data_exception;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    int lat, nbusy;
    logic [31:0] res;
    logic exc;
    data_operandA = 32'd7; data_operandB = 32'hFFFF_FFFA; ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; data_operandA = 32'd99; data_operandB = 32'd99;
    lat = 0; nbusy = 0; res = '0; exc = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (!busy) nbusy++;
      if (data_resultRDY) begin lat = n; res = data_result; exc = data_exception; break; end
    end
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL mult_latency: got %0d, want 33", lat); end
    vectors++;
    if (res !== 32'hFFFF_FFD6 || exc !== 1'b0) begin
      miscompares++; $display("FAIL mult_7x-6: got %h/%b, want ffffffd6/0", res, exc);
    end
    vectors++;
    if (nbusy !== 0) begin miscompares++; $display("FAIL busy_during_op: %0d low cycles, want 0", nbusy); end
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'hFFFF_FFD6) begin
      miscompares++;
      $display("FAIL after_done: got busy=%b rdy=%b res=%h, want 0/0/ffffffd6", busy, data_resultRDY, data_result);
    end
  endtask

  task automatic test_mult();
    logic [31:0] ta [4] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'h0001_0000, 32'h8000_0000, 32'h0000_3039, 32'h0000_0001};
    logic [31:0] tr [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
    logic        te [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [31:0] res;
    logic exc;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b0, ta[i], tb[i], lat, res, exc);
      vectors++;
      if (lat !== 33 || res !== tr[i] || exc !== te[i]) begin
        miscompares++;
        $display("FAIL mult[%0d] %h*%h: got lat=%0d res=%h exc=%b, want lat=33 res=%h exc=%b",
                 i, ta[i], tb[i], lat, res, exc, tr[i], te[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [6] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FF9C};
    logic [31:0] tb [6] = '{32'd2, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9};
    logic [31:0] tr [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF6, 32'd0, 32'h8000_0000, 32'd0, 32'd14};
    logic        te [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [31:0] res;
    logic exc;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, 1'b1, ta[i], tb[i], lat, res, exc);
      vectors++;
      if (lat !== 33 || res !== tr[i] || exc !== te[i]) begin
        miscompares++;
        $display("FAIL div[%0d] %h/%h: got lat=%0d res=%h exc=%b, want lat=33 res=%h exc=%b",
                 i, ta[i], tb[i], lat, res, exc, tr[i], te[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_protocol();
    int nrdy, first;
    logic [31:0] res;
    // both starts together in IDLE
    data_operandA = 32'd6; data_operandB = 32'd3; ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL dual_start: got busy=%b, want 0", busy); end
    // divide with a second start mid-flight
    data_operandA = 32'd100; data_operandB = 32'hFFFF_FFF6; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    nrdy = 0; first = 0; res = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        nrdy++;
        if (first == 0) begin first = n; res = data_result; end
      end
      if (n == 5) begin
        data_operandA = 32'd9; data_operandB = 32'd3; ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
      end
    end
    vectors++;
    if (nrdy !== 1 || first !== 33 || res !== 32'hFFFF_FFF6) begin
      miscompares++;
      $display("FAIL start_while_busy: got %0d rdy at %0d res=%h, want 1 at 33 res=fffffff6", nrdy, first, res);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    logic exc;
    run_op(1'b0, 1'b1, 32'd21, 32'd7, lat, res, exc);
    vectors++;
    if (lat !== 33 || res !== 32'd3 || exc !== 1'b0) begin
      miscompares++; $display("FAIL b2b_first: got lat=%0d res=%h exc=%b, want 33/3/0", lat, res, exc);
    end
    // start presented in the DONE cycle
    data_operandA = 32'd8; data_operandB = 32'd2; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL start_in_done: got busy=%b, want 0", busy); end
    // start in the IDLE cycle right after DONE
    run_op(1'b1, 1'b0, 32'd3, 32'd5, lat, res, exc);
    vectors++;
    if (lat !== 33 || res !== 32'd15 || exc !== 1'b0) begin
      miscompares++; $display("FAIL b2b_second: got lat=%0d res=%h exc=%b, want 33/f/0", lat, res, exc);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [31:0] res;
    logic exc;
    data_operandA = 32'h0000_1234; data_operandB = 32'h0000_0010; ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_midop: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    reset = 1'b0;
    run_op(1'b1, 1'b0, 32'd3, 32'd4, lat, res, exc);
    vectors++;
    if (lat !== 33 || res !== 32'd12 || exc !== 1'b0) begin
      miscompares++; $display("FAIL after_reset_mult: got lat=%0d res=%h exc=%b, want 33/c/0", lat, res, exc);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mult();
    test_div();
    test_protocol();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
